// File: rtl/conv_mac_engine.sv
// conv_mac_engine: convolution multiply-accumulate engine.
// Pops pixel/weight pairs from a first-word-fall-through FIFO. It accumulates KSIZE
// signed products per window, starting from a latched bias. Each finished window is passed
// through ReLU+clip or a signed clamp. The result is then offered on a valid/ready port
// together with a sequential window address.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   start               one-cycle pulse; accepted in IDLE/DONE only
//   bias, relu_en       run configuration, latched on an accepted start
//   fifo_empty          input FIFO empty
//   pixel, weight       FIFO head data (valid when !fifo_empty)
//   fifo_read           combinational pop strobe
//   out_data, out_addr  window result and its index
//   out_valid, out_ready  output handshake
//   busy                high in RUN or OUT
//   finish              run complete, held until the next start
module conv_mac_engine #(
    parameter int unsigned PIX_W   = 8,
    parameter int unsigned WGT_W   = 8,
    parameter int unsigned ACC_W   = 24,
    parameter int unsigned OUT_W   = 16,
    parameter int unsigned KSIZE   = 9,
    parameter int unsigned NUM_OUT = 900,
    parameter int unsigned ADDR_W  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ACC_W-1:0]  bias,
    input  logic              relu_en,
    input  logic              fifo_empty,
    input  logic [PIX_W-1:0]  pixel,
    input  logic [WGT_W-1:0]  weight,
    output logic              fifo_read,
    output logic [OUT_W-1:0]  out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              finish
);

    localparam int unsigned ProdW = PIX_W + WGT_W;
    localparam int unsigned TapW  = (KSIZE > 1) ? $clog2(KSIZE) : 1;

    localparam logic [TapW-1:0]   LastTap = TapW'(KSIZE - 1);
    localparam logic [ADDR_W-1:0] LastWin = ADDR_W'(NUM_OUT - 1);

    // Output range limits expressed at accumulator width for signed comparison.
    localparam logic signed [ACC_W-1:0] SatMax = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SatMin = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StRun, StOut, StDone} state_e;

    state_e            state_q, state_d;
    logic [TapW-1:0]   tap_cnt_q, tap_cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  bias_q;
    logic              relu_q;
    logic              load_cfg;
    logic [OUT_W-1:0]  out_data_q, out_data_d;
    // out_addr doubles as the window counter: both start at 0 and advance together.
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              out_valid_q, out_valid_d;
    logic              finish_q, finish_d;

    logic signed [ProdW-1:0] prod;
    logic signed [ACC_W-1:0] acc_sum;
    logic [OUT_W-1:0]        sat_val;

    always_comb begin
        prod    = $signed(pixel) * $signed(weight);
        acc_sum = $signed(acc_q + {{(ACC_W-ProdW){prod[ProdW-1]}}, prod});
        if (relu_q && acc_sum[ACC_W-1]) begin
            sat_val = '0;
        end else if (acc_sum > SatMax) begin
            sat_val = SatMax[OUT_W-1:0];
        end else if (acc_sum < SatMin) begin
            sat_val = SatMin[OUT_W-1:0];
        end else begin
            sat_val = acc_sum[OUT_W-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        tap_cnt_d   = tap_cnt_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_valid_d = out_valid_q;
        finish_d    = finish_q;
        load_cfg    = 1'b0;
        fifo_read   = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d    = StRun;
                    tap_cnt_d  = '0;
                    acc_d      = bias;
                    out_addr_d = '0;
                    finish_d   = 1'b0;
                    load_cfg   = 1'b1;
                end
            end
            StRun: begin
                fifo_read = !fifo_empty;
                if (!fifo_empty) begin
                    if (tap_cnt_q == LastTap) begin
                        out_data_d  = sat_val;
                        out_valid_d = 1'b1;
                        state_d     = StOut;
                        tap_cnt_d   = '0;
                        acc_d       = bias_q;
                    end else begin
                        acc_d     = acc_sum;
                        tap_cnt_d = tap_cnt_q + 1'b1;
                    end
                end
            end
            StOut: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_addr_q == LastWin) begin
                        state_d  = StDone;
                        finish_d = 1'b1;
                    end else begin
                        out_addr_d = out_addr_q + 1'b1;
                        state_d    = StRun;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            tap_cnt_q   <= '0;
            acc_q       <= '0;
            bias_q      <= '0;
            relu_q      <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
            finish_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_cnt_q   <= tap_cnt_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_valid_q <= out_valid_d;
            finish_q    <= finish_d;
            if (load_cfg) begin
                bias_q <= bias;
                relu_q <= relu_en;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_valid = out_valid_q;
    assign finish    = finish_q;
    assign busy      = (state_q == StRun) || (state_q == StOut);

endmodule

// File: tb/tb_conv_mac_engine.sv
// Self-checking bench for conv_mac_engine (KSIZE=9, NUM_OUT=4, OUT_W=16, ACC_W=24).
module tb_conv_mac_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [23:0] bias = '0;
    logic        relu_en = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [7:0]  pixel = '0;
    logic [7:0]  weight = '0;
    logic        fifo_read;
    logic [15:0] out_data;
    logic [9:0]  out_addr;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        finish;

    int n_checks = 0;
    int n_fails = 0;
    int cyc = 0;
    int pops = 0;
    int last_pop_cyc = 0;
    bit stall_en = 1'b0;
    logic [7:0] pix_q[$];
    logic [7:0] wgt_q[$];

    always #5 clk = ~clk;

    conv_mac_engine #(
        .PIX_W(8), .WGT_W(8), .ACC_W(24), .OUT_W(16),
        .KSIZE(9), .NUM_OUT(4), .ADDR_W(10)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .bias(bias), .relu_en(relu_en),
        .fifo_empty(fifo_empty), .pixel(pixel), .weight(weight), .fifo_read(fifo_read),
        .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .finish(finish)
    );

    // FWFT FIFO model: head presented on the falling edge, popped on the rising edge.
    always @(negedge clk) begin
        fifo_empty = (pix_q.size() == 0) || (stall_en && ($urandom_range(0, 1) == 1));
        pixel      = (pix_q.size() != 0) ? pix_q[0] : 8'h00;
        weight     = (wgt_q.size() != 0) ? wgt_q[0] : 8'h00;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_read) begin
            n_checks++;
            if (fifo_empty || !busy || out_valid) begin
                n_fails++;
                $display("FAIL pop_legal: fifo_read=1 with empty=%b busy=%b valid=%b, want none",
                         fifo_empty, busy, out_valid);
            end
            if (pix_q.size() != 0) begin
                void'(pix_q.pop_front());
                void'(wgt_q.pop_front());
            end
            pops         <= pops + 1;
            last_pop_cyc <= cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        pix_q.delete();
        wgt_q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_start(input logic [23:0] b, input logic r);
        bias    = b;
        relu_en = r;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic push_tap(input int p, input int w);
        pix_q.push_back(8'(p));
        wgt_q.push_back(8'(w));
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        n_checks++; if (out_data !== 16'h0) begin n_fails++;
            $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_checks++; if (out_addr !== 10'h0) begin n_fails++;
            $display("FAIL reset_out_addr: got %h want 0", out_addr); end
        n_checks++; if (out_valid !== 1'b0) begin n_fails++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fails++;
            $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (finish !== 1'b0) begin n_fails++;
            $display("FAIL reset_finish: got %b want 0", finish); end
        n_checks++; if (fifo_read !== 1'b0) begin n_fails++;
            $display("FAIL reset_fifo_read: got %b want 0", fifo_read); end
        do_reset();
    endtask

    task automatic test_single_window();
        bit ok;
        do_reset();
        do_start(24'd0, 1'b1);
        for (int i = 1; i <= 9; i++) push_tap(i, 1);
        wait_valid(ok);
        n_checks++; if (!ok) begin n_fails++;
            $display("FAIL single_timeout: out_valid=0 want 1"); end
        n_checks++; if (out_data !== 16'd45) begin n_fails++;
            $display("FAIL single_data: got %0d want 45", $signed(out_data)); end
        n_checks++; if (out_addr !== 10'd0) begin n_fails++;
            $display("FAIL single_addr: got %0d want 0", out_addr); end
        n_checks++; if (cyc != last_pop_cyc + 1) begin n_fails++;
            $display("FAIL single_latency: valid cycle %0d want %0d", cyc, last_pop_cyc + 1); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fails++;
            $display("FAIL single_pulse: out_valid=%b want 0 after one cycle", out_valid); end
    endtask

    task automatic test_sign_mode();
        bit ok;
        logic [23:0]        b_tab[3] = '{24'd0, 24'd0, 24'd100};
        logic               r_tab[3] = '{1'b1, 1'b0, 1'b1};
        logic signed [15:0] e_tab[3] = '{16'sd0, -16'sd45, 16'sd55};
        for (int k = 0; k < 3; k++) begin
            do_reset();
            do_start(b_tab[k], r_tab[k]);
            for (int i = 1; i <= 9; i++) push_tap(-i, 1);
            wait_valid(ok);
            n_checks++; if (!ok || out_data !== e_tab[k]) begin n_fails++;
                $display("FAIL sign_mode_%0d: got %0d valid=%b want %0d", k,
                         $signed(out_data), ok, e_tab[k]); end
        end
    endtask

    task automatic test_saturation();
        bit ok;
        int                 p_tab[2] = '{127, -128};
        logic               r_tab[2] = '{1'b1, 1'b0};
        logic signed [15:0] e_tab[2] = '{16'sd32767, -16'sd32768};
        for (int k = 0; k < 2; k++) begin
            do_reset();
            do_start(24'd0, r_tab[k]);
            for (int i = 0; i < 9; i++) push_tap(p_tab[k], 127);
            wait_valid(ok);
            n_checks++; if (!ok || out_data !== e_tab[k]) begin n_fails++;
                $display("FAIL saturate_%0d: got %0d valid=%b want %0d", k,
                         $signed(out_data), ok, e_tab[k]); end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        out_ready = 1'b0;
        do_start(24'd0, 1'b0);
        for (int i = 1; i <= 9; i++) push_tap(i, 3);
        for (int i = 0; i < 9; i++) push_tap(2, 1);
        wait_valid(ok);
        n_checks++; if (!ok || out_data !== 16'd135) begin n_fails++;
            $display("FAIL bp_data: got %0d valid=%b want 135", $signed(out_data), ok); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b1 || out_data !== 16'd135 || out_addr !== 10'd0)
                begin n_fails++;
                $display("FAIL bp_hold_%0d: valid=%b data=%0d addr=%0d want 1/135/0", i,
                         out_valid, $signed(out_data), out_addr); end
            n_checks++; if (fifo_read !== 1'b0) begin n_fails++;
                $display("FAIL bp_no_pop_%0d: fifo_read=%b want 0", i, fifo_read); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0 || out_addr !== 10'd1) begin n_fails++;
            $display("FAIL bp_release: valid=%b addr=%0d want 0/1", out_valid, out_addr); end
        wait_valid(ok);
        n_checks++; if (!ok || out_data !== 16'd18 || out_addr !== 10'd1) begin n_fails++;
            $display("FAIL bp_next: data=%0d addr=%0d want 18/1", $signed(out_data), out_addr);
        end
    endtask

    task automatic test_stall();
        bit ok;
        do_reset();
        stall_en = 1'b1;
        do_start(24'd0, 1'b0);
        for (int i = 1; i <= 9; i++) push_tap(i, 2);
        for (int i = 1; i <= 9; i++) push_tap(-i, 1);
        wait_valid(ok);
        n_checks++; if (!ok || out_data !== 16'd90 || out_addr !== 10'd0) begin n_fails++;
            $display("FAIL stall_w0: data=%0d addr=%0d want 90/0", $signed(out_data), out_addr);
        end
        @(negedge clk);
        wait_valid(ok);
        n_checks++; if (!ok || out_data !== 16'hFFD3 || out_addr !== 10'd1) begin n_fails++;
            $display("FAIL stall_w1: data=%0d addr=%0d want -45/1", $signed(out_data), out_addr);
        end
        stall_en = 1'b0;
    endtask

    task automatic test_full_run();
        bit ok;
        int snap;
        logic [15:0] e_tab[4] = '{16'd19, 16'd46, 16'd91, 16'd154};
        do_reset();
        do_start(24'd10, 1'b0);
        for (int w = 0; w < 4; w++)
            for (int i = 0; i < 9; i++) push_tap(w + 1, w + 1);
        for (int w = 0; w < 4; w++) begin
            wait_valid(ok);
            n_checks++; if (!ok || out_data !== e_tab[w] || out_addr !== 10'(w)) begin
                n_fails++;
                $display("FAIL full_w%0d: data=%0d addr=%0d want %0d/%0d", w,
                         $signed(out_data), out_addr, e_tab[w], w); end
            n_checks++; if (finish !== 1'b0) begin n_fails++;
                $display("FAIL full_early_finish_%0d: finish=%b want 0", w, finish); end
            @(negedge clk);
        end
        n_checks++; if (finish !== 1'b1 || busy !== 1'b0) begin n_fails++;
            $display("FAIL full_finish: finish=%b busy=%b want 1/0", finish, busy); end
        n_checks++; if (out_addr !== 10'd3) begin n_fails++;
            $display("FAIL full_addr_hold: addr=%0d want 3", out_addr); end
        snap = pops;
        for (int i = 1; i <= 9; i++) push_tap(i, 1);
        repeat (5) @(negedge clk);
        n_checks++; if (pops != snap || fifo_read !== 1'b0) begin n_fails++;
            $display("FAIL full_no_pop: pops=%0d fifo_read=%b want %0d/0", pops, fifo_read, snap);
        end
        do_start(24'd0, 1'b0);
        n_checks++; if (finish !== 1'b0 || busy !== 1'b1 || out_addr !== 10'd0) begin
            n_fails++;
            $display("FAIL restart: finish=%b busy=%b addr=%0d want 0/1/0",
                     finish, busy, out_addr); end
        wait_valid(ok);
        n_checks++; if (!ok || out_data !== 16'd45 || out_addr !== 10'd0) begin n_fails++;
            $display("FAIL restart_w0: data=%0d addr=%0d want 45/0", $signed(out_data), out_addr);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok;
        int base;
        // Run left from the previous task is mid-flight at window 1.
        base = pops;
        for (int i = 0; i < 4; i++) push_tap(5, 5);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (pops == base + 4) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++; if (!ok || busy !== 1'b1) begin n_fails++;
            $display("FAIL mid_pops: pops=%0d busy=%b want %0d/1", pops - base, busy, 4); end
        #2 reset = 1'b0;
        #1;
        n_checks++; if (out_data !== 16'h0 || out_addr !== 10'h0 || out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL mid_reset_out: data=%h addr=%h valid=%b want 0", out_data, out_addr,
                     out_valid); end
        n_checks++; if (busy !== 1'b0 || finish !== 1'b0 || fifo_read !== 1'b0) begin
            n_fails++;
            $display("FAIL mid_reset_ctl: busy=%b finish=%b fifo_read=%b want 0", busy, finish,
                     fifo_read); end
        @(negedge clk);
        pix_q.delete();
        wgt_q.delete();
        reset = 1'b1;
        @(negedge clk);
        do_start(24'd0, 1'b1);
        for (int i = 1; i <= 9; i++) push_tap(i, 1);
        wait_valid(ok);
        n_checks++; if (!ok || out_data !== 16'd45 || out_addr !== 10'd0) begin n_fails++;
            $display("FAIL mid_fresh: data=%0d addr=%0d valid=%b want 45/0", $signed(out_data),
                     out_addr, ok); end
        n_checks++; if (pix_q.size() != 0) begin n_fails++;
            $display("FAIL mid_fresh_pops: %0d taps left want 0", pix_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single_window();
        test_sign_mode();
        test_saturation();
        test_backpressure();
        test_stall();
        test_full_run();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/conv_mac_engine.md
# conv_mac_engine

Parametrised convolution multiply-accumulate engine. It pops pixel/weight pairs from a first-word-fall-through input FIFO and accumulates KSIZE signed products per output window, starting from a programmable bias. Each finished window goes through optional ReLU and saturation, then leaves on a valid/ready output port with a sequential write address. It sits between the window-fetch FIFO and the output feature-map memory. It adds explicit start, backpressure, bias, mode select and configurable geometry.

## Interface
- PIX_W, 8: pixel width (signed two's complement)
- WGT_W, 8: weight width (signed)
- ACC_W, 24: accumulator width; must be ≥ PIX_W+WGT_W+ceil(log2(KSIZE))
- OUT_W, 16: output data width (signed range before ReLU)
- KSIZE, 9: taps per window, ≥2
- NUM_OUT, 900: windows per run, ≥1
- ADDR_W, 10: output address width; 2^ADDR_W ≥ NUM_OUT
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- start  in  1  one-cycle pulse, begins a run (accepted in IDLE/DONE only)
- bias  in  ACC_W  signed bias, sampled on accepted start
- relu_en  in  1  1 = ReLU+clip, 0 = signed clamp; sampled on accepted start
- fifo_empty  in  1  input FIFO empty
- pixel  in  PIX_W  FIFO head pixel, valid when !fifo_empty
- weight  in  WGT_W  FIFO head weight, valid when !fifo_empty
- fifo_read  out  1  pop strobe, combinational
- out_data  out  OUT_W  window result
- out_addr  out  ADDR_W  window index of out_data
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts
- busy  out  1  high in RUN or OUT
- finish  out  1  run complete, held until next start

## Operation
- States: IDLE, RUN, OUT, DONE. Reset → IDLE.
- IDLE/DONE + start → RUN.
  - tap_cnt=0, win_cnt=0, acc=bias, out_addr=0, finish=0.
  - bias and relu_en are latched.
- RUN: fifo_read = !fifo_empty.
  - On each pop: acc += sext(pixel*weight) and tap_cnt++.
  - Product is a signed (PIX_W+WGT_W)-bit value, sign-extended to ACC_W. Accumulation wraps mod 2^ACC_W.
- Last tap pop (tap_cnt==KSIZE-1):
  - out_data ← f(acc+prod), out_valid ← 1, state → OUT, tap_cnt ← 0, acc ← bias.
- f, relu_en=1: negative → 0; value > 2^(OUT_W-1)-1 → 2^(OUT_W-1)-1; otherwise the value.
- f, relu_en=0: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- OUT: fifo_read=0. out_data, out_addr and out_valid hold stable until out_valid&&out_ready. On handshake:
  - out_valid ← 0.
  - If win_cnt==NUM_OUT-1 → DONE, finish ← 1, out_addr holds.
  - Else win_cnt++, out_addr++, → RUN.
- DONE: finish=1, busy=0, fifo_read=0.
- start while RUN/OUT: ignored.
- fifo_empty in RUN: no pop; acc and tap_cnt hold (stall of any length).
- Reset mid-operation: all state cleared immediately; any partial window is discarded.

## Timing
- Reset values: fifo_read 0, out_data 0, out_addr 0, out_valid 0, busy 0, finish 0. Internal acc, tap_cnt and win_cnt are 0.
- start sampled at edge E: first possible pop in cycle E+1.
- Pop on edge N is the last tap → out_valid high from N+1.
- Minimum window period: KSIZE+1 cycles (KSIZE pops + 1 OUT cycle with out_ready=1).
- out_ready may be high before out_valid; handshake completes in the first OUT cycle.
- finish rises the cycle after the final handshake. busy falls in the same cycle.
- fifo_read never asserted in IDLE, OUT or DONE, or while fifo_empty=1.

## Test plan
- Single window: KSIZE=9, bias=0, relu_en=1, pixels 1..9, weights 1, out_ready=1.
  - Expect out_data=45, out_addr=0, out_valid at pop9+1 for exactly 1 cycle.
- Sign/mode: pixels -1..-9, weights 1.
  - relu_en=1 → out_data=0.
  - relu_en=0 → out_data=-45.
  - bias=100, relu_en=1 → out_data=55.
- Saturation: OUT_W=16, pixel=127, weight=127 ×9 (sum 145161) → 32767.
  - pixel=-128, weight=127, relu_en=0 → -32768.
- Backpressure and stalls: out_ready low 5 cycles → out_data/out_addr stable, fifo_read=0.
  - fifo_empty toggled randomly in RUN → results identical to the no-stall run.
- Full run: NUM_OUT=4 → addresses 0,1,2,3, finish=1 one cycle after 4th handshake, no further pops.
  - Second start → out_addr restarts at 0, finish drops.
- Reset mid-window after 4 pops → all outputs 0 and state IDLE.
  - New start plus 9 pops → correct fresh result, no residue from the aborted window.
